// File: rtl/scr_sig_ctrl.sv
// Frame controller for the 528-bit, 14-bit-per-step scrambler/signature register.
// Optional abort input is compiled in when SCR_SIG_ABORT_EN is defined.
module scr_sig_ctrl #(
  parameter int unsigned W     = 528,
  parameter int unsigned CHUNK = 14,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     seed,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic [CHUNK-1:0] in_data,
`ifdef SCR_SIG_ABORT_EN
  input  logic             abort,
`endif
  output logic             in_ready,
  output logic [W-1:0]     sig_out,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] chunks_left
);

  localparam int unsigned Tap0 = 169;
  localparam int unsigned Tap1 = 283;
  localparam int unsigned Tap2 = 401;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     sig_q, sig_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     stepped;
  logic             abort_act;

  // One serial step: feedback from the MSB into bit 0 and the three tap positions.
  function automatic logic [W-1:0] step_bit(input logic [W-1:0] s, input logic d);
    logic         m;
    logic [W-1:0] r;
    m       = s[W-1];
    r       = {s[W-2:0], m ^ d};
    r[Tap0] = m ^ s[Tap0-1];
    r[Tap1] = m ^ s[Tap1-1];
    r[Tap2] = m ^ s[Tap2-1];
    return r;
  endfunction

  always_comb begin
    stepped = sig_q;
    for (int unsigned k = 0; k < CHUNK; k++) begin
      stepped = step_bit(stepped, in_data[k]);
    end
  end

`ifdef SCR_SIG_ABORT_EN
  assign abort_act = abort && (state_q == StRun);
`else
  assign abort_act = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sig_d   = seed;
          cnt_d   = frame_len;
          state_d = (frame_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort_act) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (in_valid) begin
          sig_d = stepped;
          cnt_d = cnt_q - LEN_W'(1);
          // RUN is only entered with a nonzero count, so this is the last chunk.
          if (cnt_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sig_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q == StRun) && !abort_act;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign sig_out     = sig_q;
  assign chunks_left = cnt_q;

endmodule

// File: tb/tb_scr_sig_ctrl.sv
// Scoreboard bench for scr_sig_ctrl: a driver pushes expected signatures and done cycles,
// a monitor pops and compares whenever done is presented.
module tb_scr_sig_ctrl;

  localparam int W     = 528;
  localparam int CHUNK = 14;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     seed = '0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             in_valid = 1'b0;
  logic [CHUNK-1:0] in_data = '0;
  logic             abort = 1'b0;
  logic             in_ready;
  logic [W-1:0]     sig_out;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] chunks_left;

  scr_sig_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .frame_len   (frame_len),
    .in_valid    (in_valid),
    .in_data     (in_data),
`ifdef SCR_SIG_ABORT_EN
    .abort       (abort),
`endif
    .in_ready    (in_ready),
    .sig_out     (sig_out),
    .busy        (busy),
    .done        (done),
    .chunks_left (chunks_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] sig;
    int           cyc;
  } exp_t;
  exp_t q[$];

  logic [W-1:0]     model_sig;
  int               model_cnt;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Galois view of the register: shift left, xor the tap mask when the MSB falls out.
  function automatic logic [W-1:0] tap_mask();
    logic [W-1:0] r;
    r = '0;
    r[0] = 1'b1; r[169] = 1'b1; r[283] = 1'b1; r[401] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] model_chunk(input logic [W-1:0] s, input logic [CHUNK-1:0] d);
    logic [W-1:0] r;
    logic         m;
    r = s;
    for (int i = 0; i < CHUNK; i++) begin
      m = r[W-1];
      r = r << 1;
      if (m) r = r ^ tap_mask();
      r[0] = r[0] ^ d[i];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 16; i++) r[i*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  // Monitor: every done must match the oldest expectation, both in cycle and value.
  always @(negedge clk) begin
    if (!rst) begin
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", W'(cyc), W'(e.cyc));
          chk("done_sig", sig_out, e.sig);
          chk("done_chunks_left", W'(chunks_left), '0);
        end
      end
      if (q.size() > 0 && cyc > q[0].cyc) begin
        void'(q.pop_front());
        fail_now("missing_done");
      end
    end
  end

  // Called at a point where the DUT is idle; returns #1 after the start edge.
  task automatic begin_frame(input logic [W-1:0] sd, input logic [LEN_W-1:0] n);
    start     = 1'b1;
    seed      = sd;
    frame_len = n;
    @(posedge clk); #1;
    start     = 1'b0;
    model_sig = sd;
    model_cnt = int'(n);
    if (n == '0) q.push_back('{sig: sd, cyc: cyc});
  endtask

  task automatic send_chunk(input logic [CHUNK-1:0] d, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = CHUNK'($urandom);
      @(negedge clk);
      chk("hold_chunks_left", W'(chunks_left), W'(model_cnt));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 8 && !ok; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        chk("run_chunks_left", W'(chunks_left), W'(model_cnt));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      fail_now("accept_timeout");
      return;
    end
    model_sig = model_chunk(model_sig, d);
    model_cnt--;
    if (model_cnt == 0) q.push_back('{sig: model_sig, cyc: cyc});
  endtask

  // Returns at a negedge where busy is low.
  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) fail_now("idle_timeout");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] expc;
    logic [W-1:0] sd;
    int           n;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sig", sig_out, '0);
    chk("reset_chunks_left", W'(chunks_left), '0);
    chk("reset_in_ready", W'(in_ready), '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);

    // Single chunk, data bit 0 ends up at bit 13.
    begin_frame('0, 16'd1);
    send_chunk(14'h0001, 0);
    wait_idle();
    expc = '0; expc[13] = 1'b1;
    chk("bit0_to_13", sig_out, expc);

    // Last sub-step data lands in bit 0.
    begin_frame('0, 16'd1);
    send_chunk(14'h2000, 0);
    wait_idle();
    expc = '0; expc[0] = 1'b1;
    chk("bit13_to_0", sig_out, expc);

    // MSB feedback hits all taps.
    sd = '0; sd[527] = 1'b1;
    begin_frame(sd, 16'd1);
    send_chunk(14'h0000, 0);
    wait_idle();
    expc = '0; expc[13] = 1'b1; expc[182] = 1'b1; expc[296] = 1'b1; expc[414] = 1'b1;
    chk("msb_feedback", sig_out, expc);

    // Gapped handshake: valid pattern 1,0,0,1,0,1.
    begin_frame('0, 16'd3);
    send_chunk(14'h0, 0);
    send_chunk(14'h0, 2);
    send_chunk(14'h0, 1);
    wait_idle();
    chk("gapped_zero_sig", sig_out, '0);

    // Start held during RUN and in the DONE cycle must be ignored.
    begin_frame(rand_w(), 16'd4);
    start     = 1'b1;
    seed      = rand_w();
    frame_len = '0;
    for (int i = 0; i < 4; i++) send_chunk(CHUNK'($urandom), $urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", W'(busy), '0);

    // Zero-length frame returns the seed.
    wait_idle();
    sd = rand_w();
    begin_frame(sd, 16'd0);
    wait_idle();
    chk("zero_len_sig", sig_out, sd);

    // Reset mid-frame discards the frame.
    begin_frame(rand_w(), 16'd5);
    send_chunk(CHUNK'($urandom), 0);
    send_chunk(CHUNK'($urandom), 0);
    do_reset();
    chk("midreset_busy", W'(busy), '0);
    chk("midreset_sig", sig_out, '0);
    chk("midreset_chunks_left", W'(chunks_left), '0);
    chk("midreset_in_ready", W'(in_ready), '0);

    // Largest frame length is latched without wrap.
    begin_frame(rand_w(), 16'hFFFF);
    @(negedge clk);
    chk("maxlen_chunks_left", W'(chunks_left), W'(16'hFFFF));
    @(posedge clk); #1;
    send_chunk(CHUNK'($urandom), 0);
    do_reset();

`ifdef SCR_SIG_ABORT_EN
    begin_frame(rand_w(), 16'd4);
    send_chunk(CHUNK'($urandom), 0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = CHUNK'($urandom);
    @(negedge clk);
    chk("abort_in_ready", W'(in_ready), '0);
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", W'(busy), '0);
    chk("abort_chunks_left", W'(chunks_left), '0);
    chk("abort_sig", sig_out, model_sig);
    begin_frame(rand_w(), 16'd2);
    send_chunk(CHUNK'($urandom), 0);
    send_chunk(CHUNK'($urandom), 1);
`endif

    // Random frames.
    repeat (20) begin
      wait_idle();
      n = $urandom_range(0, 6);
      begin_frame(rand_w(), LEN_W'(n));
      for (int i = 0; i < n; i++) send_chunk(CHUNK'($urandom), $urandom_range(0, 2));
    end

    wait_idle();
    repeat (3) @(posedge clk);
    if (q.size() != 0) fail_now("pending_expectations");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scr_sig_ctrl.md
Name: scr_sig_ctrl

Overview:
- Frame-level controller for the 528-bit, 14-bit-per-step serial-input scrambler/signature register.
- Loads a 528-bit seed on `start`, then accepts `frame_len` 14-bit chunks over a valid/ready handshake.
- Advances the register by one 14-bit step per accepted chunk and presents the final 528-bit signature with a one-cycle `done` pulse.
- Sits between the frame source and downstream signature compare/insert logic.

Parameters:
- W, 528: signature/state register width (fixed taps assume 528).
- CHUNK, 14: serial bits consumed per accepted beat.
- LEN_W, 16: width of the frame length (chunk count).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin frame; sampled only in IDLE.
- seed  input  W  initial register value, latched on accepted start.
- frame_len  input  LEN_W  number of chunks in the frame, latched on accepted start.
- in_valid  input  1  chunk available.
- in_data  input  CHUNK  chunk; bit i is the serial bit for sub-step i (LSB first).
- in_ready  output  1  high only in RUN.
- sig_out  output  W  current register contents.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; `sig_out` is final while high.
- chunks_left  output  LEN_W  remaining chunk count.

Behaviour:
- Single-bit step f(s,d):
  - m = s[527].
  - s'[0] = m^d.
  - s'[169] = m^s[168]; s'[283] = m^s[282]; s'[401] = m^s[400].
  - All other s'[i] = s[i-1].
- Chunk step: apply f 14 times, sub-step i using in_data[i], i=0..13, all in one cycle (combinational unroll).
- Reset (rst=1 at a clock edge, any state, including mid-frame):
  - state=IDLE.
  - sig register = 0; chunks_left = 0.
  - in_ready = 0, busy = 0, done = 0.
  - A partially processed frame is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with frame_len!=0: sig <= seed, chunks_left <= frame_len, go to RUN.
  - start=1 with frame_len==0: sig <= seed, go to DONE (signature = seed).
- RUN:
  - in_ready=1 (decoded from state, no extra latency).
  - On in_valid&in_ready: sig <= chunk step(sig, in_data), chunks_left <= chunks_left-1.
  - If chunks_left==1 at acceptance, go to DONE.
  - in_valid=0: sig and chunks_left hold; no timeout.
- DONE: done=1 for exactly one cycle, in_ready=0, then go to IDLE.
- start is ignored whenever state!=IDLE, including start asserted in the DONE cycle. It is not queued.
- sig_out holds its value in IDLE until the next accepted start or reset.
- Latency: start accepted at cycle 0 with in_valid continuously high gives chunks accepted at cycles 1..N and done at cycle N+1. A frame with N=0 gives done at cycle 1.
- Boundaries:
  - frame_len = 2^LEN_W-1 is legal; the count has no wrap.
  - in_data is don't-care when in_valid=0.
  - chunks_left never underflows.

Optional Feature:
- Macro: SCR_SIG_ABORT_EN.
- When defined, adds input `abort` (1 bit).
- abort=1 in RUN: go to IDLE next cycle and set chunks_left <= 0, with no done pulse.
- The sig register keeps its partial value, and any chunk presented that cycle is not accepted (in_ready forced 0 while abort=1).
- abort has no effect in IDLE/DONE.
- rst has priority over abort.
- When not defined: no abort port; behaviour exactly as above.

Test Plan:
- seed=0, frame_len=1, in_data=14'h0001 -> done at cycle 2, sig_out has only bit 13 set.
- seed=0, frame_len=1, in_data=14'h2000 -> sig_out has only bit 0 set.
- seed = only bit 527 set, frame_len=1, in_data=0 -> sig_out has exactly bits {13,182,296,414} set.
- seed=0, frame_len=3, in_valid toggling 1,0,0,1,0,1 with zero data:
  - chunks_left goes 3→2 (held)→1→0.
  - done exactly one cycle after the 3rd acceptance; sig_out=0.
- Reset mid-frame and start misuse:
  - rst asserted during RUN after 2 of 5 chunks -> next cycle IDLE, sig_out=0, no done.
  - start while busy is ignored.
  - frame_len=0 -> done at cycle 1 with sig_out=seed.
- SCR_SIG_ABORT_EN defined:
  - abort raised after 1 of 4 chunks -> IDLE next cycle, no done, sig_out = 1-chunk value.
  - A new start then runs normally.
